univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter: WIDTH, 8, register width in bits; SHALL be >= 2; CW = $clog2(WIDTH).
REQ-002 clock_in  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-005 serial_in_r  input  1  bit entering MSB on shift right.
REQ-006 serial_in_l  input  1  bit entering LSB on shift left.
REQ-007 parallel_in  input  WIDTH  load data for mode 11.
REQ-008 rotate  input  1  present only when USR_ROTATE_EN is defined (REQ-024).
REQ-009 parallel_out  output  WIDTH  register contents q.
REQ-010 serial_out_r  output  1  q[0], combinational from q.
REQ-011 serial_out_l  output  1  q[WIDTH-1], combinational from q.
REQ-012 shift_count  output  CW  shifts since last load, reset or wrap.
REQ-013 word_done  output  1  registered one-cycle pulse after the WIDTH-th shift.

Function
REQ-014 Mode 00: q, shift_count held; word_done driven 0 next edge.
REQ-015 Mode 01: q <= {serial_in_r, q[WIDTH-1:1]} per edge.
REQ-016 Mode 10: q <= {q[WIDTH-2:0], serial_in_l} per edge.
REQ-017 Mode 11: q <= parallel_in; shift_count <= 0; word_done <= 0; load latency one edge.
REQ-018 Each shift edge (01 or 10): if shift_count == WIDTH-1 then shift_count <= 0 and word_done <= 1, else shift_count <= shift_count+1 and word_done <= 0.
REQ-019 word_done SHALL be high for exactly one cycle per WIDTH consecutive shifts; direction changes between 01 and 10 do not reset the count.
REQ-020 Back-to-back words: continuous shifting SHALL produce word_done every WIDTH cycles with no gap cycle.
REQ-021 serial_out_r/serial_out_l SHALL show the bit about to be shifted out, before the edge that discards it.
REQ-022 Hold or load interrupting a word SHALL not assert word_done; load discards partial count.

Reset
REQ-023 reset asserted SHALL immediately (no clock) force q = 0, shift_count = 0, word_done = 0, hence serial_out_r = serial_out_l = 0; held while reset high, including mid-word; first update on first rising edge after deassertion.

Configuration
REQ-024 Macro USR_ROTATE_EN: defined -> rotate port exists; with rotate=1, mode 01 uses q[0] in place of serial_in_r and mode 10 uses q[WIDTH-1] in place of serial_in_l; counting/word_done unchanged; rotate ignored in modes 00/11.
REQ-025 Macro undefined -> no rotate port, no rotate logic; shifts always take serial inputs.

Verification (WIDTH=8)
REQ-026 reset pulse then mode 11, parallel_in=0xA5 -> parallel_out=0xA5 after one edge, shift_count=0, word_done=0.
REQ-027 from 0xA5, mode 01 for 8 edges, serial_in_r=1,0,1,1,1,0,0,0 -> serial_out_r before each edge 1,0,1,0,0,1,0,1; final q=0x1D; word_done high only in cycle after 8th edge; shift_count back to 0.
REQ-028 load 0x81, mode 10 with serial_in_l=0 for 3 edges -> serial_out_l 1,0,0; q=0x08; shift_count=3.
REQ-029 after 3 shifts, assert reset between edges -> all outputs 0 before next edge; after release, 8 shifts needed for word_done.
REQ-030 mode 00 for 5 edges at q=0x08, shift_count=3 -> values unchanged, word_done 0; then load mid-word -> shift_count 0, no word_done.
REQ-031 USR_ROTATE_EN: load 0x01, rotate=1, mode 01 one edge -> 0x80; mode 10 one edge -> 0x01; undefined build: 0x01, mode 01, serial_in_r=0 -> 0x00.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- universal shift register with word-boundary tracking.
//
// Holds, shifts right, shifts left or parallel-loads a WIDTH-bit register
// every rising clock edge, selected by mode. Shifts are counted modulo
// WIDTH; the edge that completes a full word of shifts raises word_done
// for exactly one cycle.
//
// Optional feature macro: USR_ROTATE_EN
//   defined   -> adds the rotate input; when high, shifts recirculate the
//                outgoing bit instead of taking the serial input.
//   undefined -> no rotate port; shifts always take the serial inputs.
//
// Ports:
//   clock_in      in   1      rising-edge clock
//   reset         in   1      asynchronous active-high reset
//   mode          in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   serial_in_r   in   1      bit entering the MSB on shift right
//   serial_in_l   in   1      bit entering the LSB on shift left
//   parallel_in   in   WIDTH  load data for mode 11
//   rotate        in   1      rotate select (USR_ROTATE_EN builds only)
//   parallel_out  out  WIDTH  register contents
//   serial_out_r  out  1      LSB, the bit a right shift will discard
//   serial_out_l  out  1      MSB, the bit a left shift will discard
//   shift_count   out  CW     shifts since last load, reset or wrap
//   word_done     out  1      one-cycle pulse after the WIDTH-th shift

module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CW   = $clog2(WIDTH)
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             serial_in_r,
    input  logic             serial_in_l,
    input  logic [WIDTH-1:0] parallel_in,
`ifdef USR_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out_r,
    output logic             serial_out_l,
    output logic [CW-1:0]    shift_count,
    output logic             word_done
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    mode_e            mode_sel;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]    count;
    logic             done;
    logic             fill_r;
    logic             fill_l;
    logic             word_end;

    assign mode_sel = mode_e'(mode);

    // Bits entering the register on a shift.
    always_comb begin
        fill_r = serial_in_r;
        fill_l = serial_in_l;
`ifdef USR_ROTATE_EN
        if (rotate) begin
            fill_r = q[0];
            fill_l = q[WIDTH-1];
        end
`endif
    end

    assign word_end = (count == LAST_COUNT);

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            q     <= '0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            unique case (mode_sel)
                MODE_HOLD: begin
                    done <= 1'b0;
                end
                MODE_SHR: begin
                    q     <= {fill_r, q[WIDTH-1:1]};
                    count <= word_end ? '0 : count + 1'b1;
                    done  <= word_end;
                end
                MODE_SHL: begin
                    q     <= {q[WIDTH-2:0], fill_l};
                    count <= word_end ? '0 : count + 1'b1;
                    done  <= word_end;
                end
                MODE_LOAD: begin
                    q     <= parallel_in;
                    count <= '0;
                    done  <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

    assign parallel_out = q;
    assign serial_out_r = q[0];
    assign serial_out_l = q[WIDTH-1];
    assign shift_count  = count;
    assign word_done    = done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg -- directed and randomized checks of univ_shift_reg
// (WIDTH = 8) against an arithmetic reference model.
// Build with +define+USR_ROTATE_EN to exercise the rotate feature.

module tb_univ_shift_reg;

    localparam int unsigned W    = 8;
    localparam int unsigned MASK = 32'hFF;

    logic         clock_in = 1'b0;
    logic         reset;
    logic [1:0]   mode;
    logic         serial_in_r;
    logic         serial_in_l;
    logic [W-1:0] parallel_in;
    logic         rotate;
    logic [W-1:0] parallel_out;
    logic         serial_out_r;
    logic         serial_out_l;
    logic [2:0]   shift_count;
    logic         word_done;

    int total = 0;
    int bad   = 0;

    // Reference model state: register value, shifts into the current word,
    // and whether the previous edge completed a word.
    int unsigned m_q;
    int unsigned m_cnt;
    bit          m_done;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .mode        (mode),
        .serial_in_r (serial_in_r),
        .serial_in_l (serial_in_l),
        .parallel_in (parallel_in),
`ifdef USR_ROTATE_EN
        .rotate      (rotate),
`endif
        .parallel_out(parallel_out),
        .serial_out_r(serial_out_r),
        .serial_out_l(serial_out_l),
        .shift_count (shift_count),
        .word_done   (word_done)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},    32'(parallel_out), m_q);
        check({tag, ".sor"},  32'(serial_out_r), m_q & 1);
        check({tag, ".sol"},  32'(serial_out_l), (m_q >> (W - 1)) & 1);
        check({tag, ".cnt"},  32'(shift_count),  m_cnt);
        check({tag, ".done"}, 32'(word_done),    32'(m_done));
    endtask

    task automatic model_reset();
        m_q    = 0;
        m_cnt  = 0;
        m_done = 0;
    endtask

    // Advance the model by one edge using the current inputs, clock the DUT,
    // then compare just after the edge.
    task automatic tick(input string tag);
        int unsigned fr, fl;
        bit          rot;
        rot = 0;
`ifdef USR_ROTATE_EN
        rot = (rotate === 1'b1);
`endif
        fr = rot ? (m_q & 1) : 32'(serial_in_r);
        fl = rot ? ((m_q >> (W - 1)) & 1) : 32'(serial_in_l);
        case (mode)
            2'b00: m_done = 0;
            2'b01, 2'b10: begin
                if (mode == 2'b01) m_q = (m_q >> 1) | (fr << (W - 1));
                else               m_q = ((m_q << 1) | fl) & MASK;
                m_cnt = m_cnt + 1;
                if (m_cnt == W) begin
                    m_cnt  = 0;
                    m_done = 1;
                end else begin
                    m_done = 0;
                end
            end
            default: begin
                m_q    = 32'(parallel_in);
                m_cnt  = 0;
                m_done = 0;
            end
        endcase
        @(posedge clock_in);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [7:0] sin_seq;
        logic [7:0] sor_seq;

        reset       = 1'b1;
        mode        = 2'b00;
        serial_in_r = 1'b0;
        serial_in_l = 1'b0;
        parallel_in = '0;
        rotate      = 1'b0;
        model_reset();
        #1;
        check_all("por");
        @(posedge clock_in);
        #3;
        reset = 1'b0;
        @(posedge clock_in);
        #1;
        check_all("post_reset_idle");

        // Load 0xA5.
        mode        = 2'b11;
        parallel_in = 8'hA5;
        tick("load_a5");

        // Eight right shifts with a known serial stream.
        sin_seq = 8'b0001_1101;   // bit i applied on edge i: 1,0,1,1,1,0,0,0
        sor_seq = 8'b1010_0101;   // serial_out_r before edge i: 1,0,1,0,0,1,0,1
        mode = 2'b01;
        for (int i = 0; i < 8; i++) begin
            serial_in_r = sin_seq[i];
            check("shr_sor_pre", 32'(serial_out_r), 32'(sor_seq[i]));
            tick("shr_word");
            if (i < 7) check("shr_no_done", 32'(word_done), 0);
        end
        check("shr_final_q", 32'(parallel_out), 32'h1D);
        check("shr_done", 32'(word_done), 1);
        check("shr_cnt_wrap", 32'(shift_count), 0);
        mode = 2'b00;
        tick("shr_done_drop");
        check("shr_done_low", 32'(word_done), 0);

        // Load 0x81, three left shifts of 0.
        mode        = 2'b11;
        parallel_in = 8'h81;
        tick("load_81");
        mode        = 2'b10;
        serial_in_l = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("shl_sol_pre", 32'(serial_out_l), (i == 0) ? 1 : 0);
            tick("shl3");
        end
        check("shl_q08", 32'(parallel_out), 32'h08);
        check("shl_cnt3", 32'(shift_count), 3);

        // Hold five edges, then load mid-word.
        mode = 2'b00;
        for (int i = 0; i < 5; i++) tick("hold5");
        check("hold_cnt3", 32'(shift_count), 3);
        mode        = 2'b11;
        parallel_in = 8'h3C;
        tick("load_mid");
        check("load_mid_cnt", 32'(shift_count), 0);

        // Three shifts, asynchronous reset between edges, then a full word.
        mode        = 2'b01;
        serial_in_r = 1'b1;
        for (int i = 0; i < 3; i++) tick("pre_reset");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        @(posedge clock_in);
        #1;
        check_all("reset_held");
        #2;
        reset = 1'b0;
        @(posedge clock_in);
        #1;
        m_q   = (m_q >> 1) | (1 << (W - 1));
        m_cnt = 1;
        check_all("first_after_reset");
        for (int i = 1; i < 8; i++) begin
            mode = (i % 2 == 0) ? 2'b01 : 2'b10;   // direction changes keep counting
            tick("after_reset_word");
        end
        check("after_reset_done", 32'(word_done), 1);
        tick("back_to_back");
        check("b2b_no_done", 32'(word_done), 0);

`ifdef USR_ROTATE_EN
        mode        = 2'b11;
        parallel_in = 8'h01;
        tick("rot_load");
        rotate      = 1'b1;
        serial_in_r = 1'b0;
        serial_in_l = 1'b0;
        mode        = 2'b01;
        tick("rot_r");
        check("rot_r_80", 32'(parallel_out), 32'h80);
        mode = 2'b10;
        tick("rot_l");
        check("rot_l_01", 32'(parallel_out), 32'h01);
        rotate = 1'b0;
`else
        mode        = 2'b11;
        parallel_in = 8'h01;
        tick("norot_load");
        mode        = 2'b01;
        serial_in_r = 1'b0;
        tick("norot_r");
        check("norot_r_00", 32'(parallel_out), 32'h00);
`endif

        // Randomized traffic, biased toward shifting.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            mode        = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
            serial_in_r = 1'($urandom);
            serial_in_l = 1'($urandom);
            parallel_in = 8'($urandom);
`ifdef USR_ROTATE_EN
            rotate = 1'($urandom);
`endif
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                model_reset();
                #1;
                check_all("rand_reset");
                #2;
                reset = 1'b0;
            end
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
